// File: rtl/pce_pkg.sv
// Shared defaults, FSM state encoding and address-table layout for the QC encoder.
package pce_pkg;

  localparam int unsigned DEF_K_BITS = 4320;
  localparam int unsigned DEF_M      = 360;
  localparam int unsigned DEF_P_BITS = 4320;
  localparam int unsigned DEF_W      = 3;
  localparam int unsigned DEF_ROWS   = DEF_K_BITS / DEF_M;
  localparam int unsigned DEF_AW     = $clog2(DEF_P_BITS);

  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PAD  = 3'd2;
  localparam logic [2:0] ST_ACC  = 3'd3;
  localparam logic [2:0] ST_PAR  = 3'd4;

  // Row g, entry w sits at bit offset (g*W + w)*AW of the flattened table.
  typedef logic [DEF_ROWS-1:0][DEF_W-1:0][DEF_AW-1:0] addr_tbl_t;

  // Counter width that stays at least one bit for trivial ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Generated default table for the default geometry; specific codes pass their own TABLE.
  function automatic addr_tbl_t default_table();
    addr_tbl_t t;
    for (int r = 0; r < int'(DEF_ROWS); r++) begin
      for (int w = 0; w < int'(DEF_W); w++) begin
        t[r][w] = DEF_AW'((r * 977 + w * 1447 + 13) % int'(DEF_P_BITS));
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/pce_addr_rom.sv
// Per-group parity address ROM; the row is registered when the group pointer moves.
module pce_addr_rom #(
  parameter int unsigned ROWS = 1,
  parameter int unsigned W    = 1,
  parameter int unsigned AW   = 1,
  parameter int unsigned GW   = 1,
  parameter logic [ROWS*W*AW-1:0] TABLE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [GW-1:0]         row_i,
  output logic [W-1:0][AW-1:0]  addr_o
);

  logic [W-1:0][AW-1:0] addr_q;

  // Prefetch the next group's addresses; reset leaves row 0 ready for a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= TABLE[W*AW-1:0];
    end else if (en_i) begin
      addr_q <= TABLE[int'(row_i)*W*AW +: W*AW];
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/pce_qc_enc.sv
// Quasi-cyclic systematic encoder: echoes info bits, accumulates parity, then streams it.
module pce_qc_enc
  import pce_pkg::*;
#(
  parameter int unsigned K_BITS = DEF_K_BITS,
  parameter int unsigned M      = DEF_M,
  parameter int unsigned P_BITS = DEF_P_BITS,
  parameter int unsigned W      = DEF_W,
  parameter logic [(K_BITS/M)*W*$clog2(P_BITS)-1:0] TABLE =
    ((K_BITS/M)*W*$clog2(P_BITS))'(default_table())
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_valid,
  input  logic din_last,
  output logic din_ready,
  output logic dout,
  output logic dout_valid,
  output logic dout_last,
  input  logic dout_ready,
  output logic busy
);

  localparam int unsigned Q    = P_BITS / M;
  localparam int unsigned ROWS = K_BITS / M;
  localparam int unsigned AW   = $clog2(P_BITS);
  localparam int unsigned SW   = AW + 1;
  localparam int unsigned KW   = clog2_min1(K_BITS);
  localparam int unsigned GW   = clog2_min1(ROWS);
  localparam int unsigned JW   = clog2_min1(M);
  localparam int unsigned UW   = clog2_min1(W);
  localparam int unsigned PW   = $clog2(P_BITS + 1);

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [JW-1:0]       j_q, j_d;
  logic [GW-1:0]       grp_q, grp_d;
  logic [AW-1:0]       off_q, off_d;
  logic [UW-1:0]       upd_q, upd_d;
  logic                bit_q, bit_d;
  logic [P_BITS-1:0]   par_q, par_d;
  logic                acc_q, acc_d;
  logic [PW-1:0]       pidx_q, pidx_d;
  logic                dout_q, dout_d;
  logic                dvalid_q, dvalid_d;
  logic                dlast_q, dlast_d;
  logic                busy_q, busy_d;
  logic                run_q;

  logic                 can_load_c, fire_c, wrap_c;
  logic                 upd_en_c, upd_bit_c, last_upd_c, adv_c;
  logic [UW-1:0]        upd_w_c;
  logic [SW-1:0]        sum_c;
  logic [AW-1:0]        upd_addr_c;
  logic                 pbit_c;
  logic [W-1:0][AW-1:0] rom_addr;

  pce_addr_rom #(
    .ROWS  (ROWS),
    .W     (W),
    .AW    (AW),
    .GW    (GW),
    .TABLE (TABLE)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (adv_c),
    .row_i  (grp_d),
    .addr_o (rom_addr)
  );

  assign can_load_c = !dvalid_q || dout_ready;
  assign din_ready  = run_q && (state_q == ST_IDLE || state_q == ST_LOAD) &&
                      (upd_q == '0) && can_load_c;
  assign fire_c     = din_valid && din_ready;
  assign wrap_c     = (k_q == KW'(K_BITS - 1));
  assign pbit_c     = acc_q ^ par_q[pidx_q[AW-1:0]];

  // Pick this cycle's table update and fold its address back into range.
  always_comb begin
    upd_en_c  = 1'b0;
    upd_bit_c = 1'b0;
    upd_w_c   = '0;
    if (fire_c) begin
      upd_en_c  = 1'b1;
      upd_bit_c = din;
    end else if (upd_q != '0) begin
      upd_en_c  = 1'b1;
      upd_bit_c = bit_q;
      upd_w_c   = upd_q;
    end
    last_upd_c = upd_en_c && (upd_w_c == UW'(W - 1));
    adv_c      = last_upd_c || (state_q == ST_PAD && upd_q == '0);
    sum_c      = SW'(rom_addr[upd_w_c]) + SW'(off_q);
    upd_addr_c = (sum_c >= SW'(P_BITS)) ? AW'(sum_c - SW'(P_BITS)) : sum_c[AW-1:0];
  end

  // Next-state logic: FSM, index counters, parity RMW and output register.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    j_d      = j_q;
    grp_d    = grp_q;
    off_d    = off_q;
    upd_d    = upd_q;
    bit_d    = bit_q;
    par_d    = par_q;
    acc_d    = acc_q;
    pidx_d   = pidx_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    dlast_d  = dlast_q;
    busy_d   = busy_q;

    // A new frame starts from a clean parity array before its first update lands.
    if (fire_c && state_q == ST_IDLE) begin
      par_d  = '0;
      acc_d  = 1'b0;
      busy_d = 1'b1;
    end
    if (upd_en_c) begin
      par_d[upd_addr_c] = par_d[upd_addr_c] ^ upd_bit_c;
      upd_d = last_upd_c ? '0 : UW'(upd_w_c + UW'(1));
    end
    if (fire_c) begin
      bit_d = din;
    end

    // Offset tracks j*Q incrementally; the frame end returns everything to group 0.
    if (adv_c) begin
      if (wrap_c) begin
        k_d   = '0;
        j_d   = '0;
        grp_d = '0;
        off_d = '0;
      end else begin
        k_d = k_q + KW'(1);
        if (j_q == JW'(M - 1)) begin
          j_d   = '0;
          off_d = '0;
          grp_d = grp_q + GW'(1);
        end else begin
          j_d   = j_q + JW'(1);
          off_d = off_q + AW'(Q);
        end
      end
    end

    if (dvalid_q && dout_ready) begin
      dvalid_d = 1'b0;
      dlast_d  = 1'b0;
    end
    if (fire_c) begin
      dout_d   = din;
      dvalid_d = 1'b1;
      dlast_d  = 1'b0;
    end else if (state_q == ST_PAR && can_load_c && pidx_q != PW'(P_BITS)) begin
      dout_d   = pbit_c;
      acc_d    = pbit_c;
      dvalid_d = 1'b1;
      dlast_d  = (pidx_q == PW'(P_BITS - 1));
      pidx_d   = pidx_q + PW'(1);
    end

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (fire_c) begin
          if (wrap_c)        state_d = ST_ACC;
          else if (din_last) state_d = ST_PAD;
          else               state_d = ST_LOAD;
        end
      end
      ST_PAD: begin
        if (upd_q == '0 && wrap_c) state_d = ST_ACC;
      end
      ST_ACC: begin
        if (upd_q == '0 || last_upd_c) state_d = ST_PAR;
      end
      ST_PAR: begin
        if (dvalid_q && dlast_q && dout_ready) begin
          state_d = ST_IDLE;
          pidx_d  = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      j_q      <= '0;
      grp_q    <= '0;
      off_q    <= '0;
      upd_q    <= '0;
      bit_q    <= 1'b0;
      par_q    <= '0;
      acc_q    <= 1'b0;
      pidx_q   <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      j_q      <= j_d;
      grp_q    <= grp_d;
      off_q    <= off_d;
      upd_q    <= upd_d;
      bit_q    <= bit_d;
      par_q    <= par_d;
      acc_q    <= acc_d;
      pidx_q   <= pidx_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      dlast_q  <= dlast_d;
      busy_q   <= busy_d;
      run_q    <= 1'b1;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dvalid_q;
  assign dout_last  = dlast_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pce_qc_enc.sv
// Self-checking bench for pce_qc_enc on the small K=8, M=4, P=8, W=2 geometry.
module tb_pce_qc_enc;

  localparam int K_BITS = 8;
  localparam int M      = 4;
  localparam int P_BITS = 8;
  localparam int W      = 2;
  localparam int Q      = P_BITS / M;
  localparam logic [11:0] TB_TABLE = {3'd4, 3'd3, 3'd6, 3'd1};

  logic clk = 1'b0;
  logic rst_n, din, din_valid, din_last, din_ready;
  logic dout, dout_valid, dout_last, dout_ready, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int tbl [2][2] = '{'{1, 6}, '{3, 4}};
  bit exp_q [$];

  pce_qc_enc #(
    .K_BITS (K_BITS),
    .M      (M),
    .P_BITS (P_BITS),
    .W      (W),
    .TABLE  (TB_TABLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: info bits echoed, then running XOR of the QC parity accumulation.
  function automatic void build_exp(input int n, input logic [7:0] bits);
    bit par [P_BITS];
    bit run;
    exp_q.delete();
    foreach (par[i]) par[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(bits[k]);
      if (bits[k]) begin
        for (int w = 0; w < W; w++) begin
          par[(tbl[k / M][w] + (k % M) * Q) % P_BITS] ^= 1'b1;
        end
      end
    end
    run = 1'b0;
    for (int i = 0; i < P_BITS; i++) begin
      run = run ^ par[i];
      exp_q.push_back(run);
    end
  endfunction

  task automatic reset_pulse();
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    dout_ready = 1'b1;
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_dvalid", int'(dout_valid), 0);
    chk("rst_dlast", int'(dout_last), 0);
    chk("rst_din_ready", int'(din_ready), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", int'(din_ready), 0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", int'(din_ready), 1);
  endtask

  // rmode: 0 always ready, 1 ready pattern 1,0,0, 2 random; rst_at: output count that triggers a reset.
  task automatic run_frame(input int n, input logic [7:0] bits, input int rmode,
                           input bit vrand, input int rst_at);
    int ptr, outs, total, cyc;
    logic prev_stall, prev_d, prev_l;
    build_exp(n, bits);
    total = n + P_BITS;
    ptr = 0; outs = 0; cyc = 0;
    prev_stall = 1'b0; prev_d = 1'b0; prev_l = 1'b0;
    while (outs < total && cyc < 600) begin
      @(negedge clk);
      case (rmode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = ((cyc % 3) == 0);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (ptr < n) begin
        din_valid = vrand ? ($urandom_range(0, 9) < 7) : 1'b1;
        din       = din_valid ? bits[ptr] : 1'($urandom_range(0, 1));
        din_last  = din_valid && (ptr == n - 1);
      end else begin
        din_valid = vrand ? 1'($urandom_range(0, 1)) : 1'b0;
        din       = 1'($urandom_range(0, 1));
        din_last  = 1'($urandom_range(0, 1));
      end
      #1;
      if (prev_stall) begin
        chk("hold_valid", int'(dout_valid), 1);
        chk("hold_dout", int'(dout), int'(prev_d));
        chk("hold_last", int'(dout_last), int'(prev_l));
      end
      if (ptr >= n && din_valid) chk("ignored_din_ready", int'(din_ready), 0);
      if (dout_valid && dout_ready) begin
        chk("dout", int'(dout), int'(exp_q[outs]));
        chk("dout_last", int'(dout_last), int'(outs == total - 1));
        chk("busy_mid", int'(busy), 1);
        outs++;
      end
      if (din_valid && din_ready) ptr++;
      prev_stall = dout_valid && !dout_ready;
      prev_d = dout;
      prev_l = dout_last;
      cyc++;
      if (rst_at >= 0 && outs == rst_at) begin
        @(posedge clk);
        #2;
        reset_pulse();
        return;
      end
    end
    chk("out_count", outs, total);
    chk("in_count", ptr, n);
    @(negedge clk);
    din_valid  = 1'b0;
    din_last   = 1'b0;
    dout_ready = 1'b1;
    #1;
    chk("busy_end", int'(busy), 0);
    chk("dvalid_end", int'(dout_valid), 0);
    chk("ready_end", int'(din_ready), 1);
  endtask

  initial begin
    rst_n      = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    dout_ready = 1'b0;
    #3;
    reset_pulse();

    run_frame(8, 8'h00, 0, 1'b0, -1);
    run_frame(8, 8'h01, 0, 1'b0, -1);
    run_frame(8, 8'h20, 0, 1'b0, -1);
    run_frame(4, 8'h01, 0, 1'b0, -1);
    run_frame(8, 8'h01, 1, 1'b0, -1);
    run_frame(8, 8'h01, 0, 1'b0, 11);
    run_frame(8, 8'h00, 0, 1'b0, -1);

    for (int f = 0; f < 40; f++) begin
      run_frame(int'($urandom_range(1, 8)), 8'($urandom), 2, 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
